// File: rtl/named_genblk_pkg.sv
// Shared constants and helpers for the named-genblk FIFO: depth selection and pointer sizing.
package named_genblk_pkg;

  localparam int CNT_W = 3;

  typedef logic [31:0] depth_word_t;

  function automatic int depth_of(input int p);
    case (p)
      1:       return 2;
      2:       return 3;
      3:       return 5;
      default: return 7;
    endcase
  endfunction

  // Narrowest pointer that can address every entry of a d-deep store.
  function automatic int ptr_bits(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/named_genblk_ptr.sv
// Modulo-DEPTH pointer: advances by one on inc and wraps DEPTH-1 -> 0 (works for non-power-of-2 depths).
module named_genblk_ptr
  import named_genblk_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = ptr_bits(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/named_genblk_fifo.sv
// Valid/ready FIFO whose depth (2/3/5/7) is picked by P through named generate blocks;
// flags a sticky error when the upstream depth word disagrees with the elaborated depth.
module named_genblk_fifo
  import named_genblk_pkg::*;
#(
  parameter int P     = 0,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  depth_word_t      cfg_depth,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output depth_word_t      capacity,
  output logic             depth_err
);

  localparam int DEPTH = depth_of(P);
  localparam int PTR_W = ptr_bits(DEPTH);

  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] head_dat;

  // Handshake readiness depends only on registered count, never on out_ready.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? head_dat : '0;

  named_genblk_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  named_genblk_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 1'b1;
    end else if (pop && !push) begin
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_err <= 1'b0;
    end else if (cfg_depth != depth_word_t'(DEPTH)) begin
      depth_err <= 1'b1;
    end
  end

  // Per-depth storage; vld marks occupied entries so stale data never reaches the head.
  if (P == 1) begin : blk1
    localparam int N = 2;
    logic             vld [N];
    logic [WIDTH-1:0] mem [N];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < N; i++) vld[i] <= 1'b0;
      end else begin
        if (pop) vld[rd_ptr] <= 1'b0;
        if (push) begin
          vld[wr_ptr] <= 1'b1;
          mem[wr_ptr] <= in_data;
        end
      end
    end
    assign head_dat = vld[rd_ptr] ? mem[rd_ptr] : '0;
  end else if (P == 2) begin : blk2
    localparam int N = 3;
    logic             vld [N];
    logic [WIDTH-1:0] mem [N];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < N; i++) vld[i] <= 1'b0;
      end else begin
        if (pop) vld[rd_ptr] <= 1'b0;
        if (push) begin
          vld[wr_ptr] <= 1'b1;
          mem[wr_ptr] <= in_data;
        end
      end
    end
    assign head_dat = vld[rd_ptr] ? mem[rd_ptr] : '0;
  end else if (P == 3) begin : blk3
    localparam int N = 5;
    logic             vld [N];
    logic [WIDTH-1:0] mem [N];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < N; i++) vld[i] <= 1'b0;
      end else begin
        if (pop) vld[rd_ptr] <= 1'b0;
        if (push) begin
          vld[wr_ptr] <= 1'b1;
          mem[wr_ptr] <= in_data;
        end
      end
    end
    assign head_dat = vld[rd_ptr] ? mem[rd_ptr] : '0;
  end else begin : blk4
    localparam int N = 7;
    logic             vld [N];
    logic [WIDTH-1:0] mem [N];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < N; i++) vld[i] <= 1'b0;
      end else begin
        if (pop) vld[rd_ptr] <= 1'b0;
        if (push) begin
          vld[wr_ptr] <= 1'b1;
          mem[wr_ptr] <= in_data;
        end
      end
    end
    assign head_dat = vld[rd_ptr] ? mem[rd_ptr] : '0;
  end

  // Capacity is read back from the elaborated flag array rather than recomputed.
  if (P == 1) begin : cap1
    assign capacity = $bits(blk1.vld);
  end else if (P == 2) begin : cap2
    assign capacity = $bits(blk2.vld);
  end else if (P == 3) begin : cap3
    assign capacity = $bits(blk3.vld);
  end else begin : cap4
    assign capacity = $bits(blk4.vld);
  end

endmodule
